// File: rtl/ibex_wb_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_wb_buffer_if
//  Description : Bundle of the writeback-buffer handshake and register-file
//                write signals. The slave modport is the buffer's view, the
//                master modport is the view of the ID/EX stage plus LSU.
//  Ports       : en_wb_i / instr_type_wb_i / pc_id_i / rf_*_id_i - offered
//                instruction; lsu_resp_* / rf_wdata_lsu_i - LSU response;
//                ready_wb_o, rf_*_wb_o, pending_*_o, outstanding_*_o,
//                pc_wb_o, instr_done_wb_o, perf_* - buffer results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ibex_wb_buffer_if #(
    parameter int DataWidth = 32
);
    // offered instruction
    logic                 en_wb_i;
    logic [1:0]           instr_type_wb_i;
    logic [31:0]          pc_id_i;
    logic                 instr_is_compressed_id_i;
    logic                 instr_perf_count_id_i;
    logic [4:0]           rf_waddr_id_i;
    logic [DataWidth-1:0] rf_wdata_id_i;
    logic                 rf_we_id_i;
    logic                 rf_dst_fp_id_i;
    // LSU response
    logic                 lsu_resp_valid_i;
    logic                 lsu_resp_err_i;
    logic [DataWidth-1:0] rf_wdata_lsu_i;
    // buffer results
    logic                 ready_wb_o;
    logic [4:0]           rf_waddr_wb_o;
    logic [DataWidth-1:0] rf_wdata_wb_o;
    logic                 rf_we_int_wb_o;
    logic                 rf_we_fp_wb_o;
    logic [31:0]          pending_int_o;
    logic [31:0]          pending_fp_o;
    logic                 outstanding_load_wb_o;
    logic                 outstanding_store_wb_o;
    logic [31:0]          pc_wb_o;
    logic                 instr_done_wb_o;
    logic                 perf_instr_ret_wb_o;
    logic                 perf_instr_ret_compressed_wb_o;

    modport slave (
        input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i,
               rf_we_id_i, rf_dst_fp_id_i, lsu_resp_valid_i, lsu_resp_err_i,
               rf_wdata_lsu_i,
        output ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_int_wb_o,
               rf_we_fp_wb_o, pending_int_o, pending_fp_o,
               outstanding_load_wb_o, outstanding_store_wb_o, pc_wb_o,
               instr_done_wb_o, perf_instr_ret_wb_o,
               perf_instr_ret_compressed_wb_o
    );

    modport master (
        output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i,
               rf_we_id_i, rf_dst_fp_id_i, lsu_resp_valid_i, lsu_resp_err_i,
               rf_wdata_lsu_i,
        input  ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_int_wb_o,
               rf_we_fp_wb_o, pending_int_o, pending_fp_o,
               outstanding_load_wb_o, outstanding_store_wb_o, pc_wb_o,
               instr_done_wb_o, perf_instr_ret_wb_o,
               perf_instr_ret_compressed_wb_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_wb_buffer
//  Description : In-order writeback buffer of Depth entries. Instructions
//                accepted from ID/EX are queued; the head retires at once if
//                it is OTHER, or on the LSU response if it is LOAD/STORE.
//                Register-file writes happen only in the head's retire cycle.
//  Ports       : clk_i - clock (rising edge)
//                rst_i - synchronous active-high reset
//                wb    - ibex_wb_buffer_if.slave bundle (instruction offer,
//                        LSU response, RF write port, hazard masks, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module ibex_wb_buffer #(
    parameter int DataWidth = 32,
    parameter int Depth     = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    ibex_wb_buffer_if.slave     wb
);

    localparam int PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CNT_W = $clog2(Depth + 1);

    localparam logic [PTR_W-1:0] C_LAST_PTR  = PTR_W'(Depth - 1);
    localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(Depth);

    // wb_instr_type_e encoding
    localparam logic [1:0] C_TYPE_LOAD  = 2'b00;
    localparam logic [1:0] C_TYPE_STORE = 2'b01;

    // ------------------------------------------------------------------
    // Entry storage and bookkeeping
    // ------------------------------------------------------------------
    logic [1:0]           r_type  [Depth];
    logic [4:0]           r_waddr [Depth];
    logic [DataWidth-1:0] r_wdata [Depth];
    logic                 r_we    [Depth];
    logic                 r_fp    [Depth];
    logic [31:0]          r_pc    [Depth];
    logic                 r_cmp   [Depth];
    logic                 r_cnt   [Depth];
    logic [Depth-1:0]     r_valid;

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    logic w_nonempty;
    logic w_head_lsu;
    logic w_head_load;
    logic w_retire;
    logic w_lsu_err;
    logic w_write;
    logic w_we_int;
    logic w_we_fp;
    logic w_ready;
    logic w_enq;

    always_comb begin
        w_nonempty  = (r_count != '0);
        w_head_load = w_nonempty & (r_type[r_head] == C_TYPE_LOAD);
        w_head_lsu  = w_head_load |
                      (w_nonempty & (r_type[r_head] == C_TYPE_STORE));
        // The LSU response only matters to a LOAD/STORE head; it is
        // ignored when empty or when the head is OTHER.
        w_retire    = w_nonempty & (~w_head_lsu | wb.lsu_resp_valid_i);
        w_lsu_err   = w_head_lsu & wb.lsu_resp_valid_i & wb.lsu_resp_err_i;
        w_write     = w_retire & r_we[r_head] &
                      (r_type[r_head] != C_TYPE_STORE) & ~w_lsu_err;
        w_we_fp     = w_write & r_fp[r_head];
        // x0 is hardwired to zero, so an integer write to it is dropped.
        w_we_int    = w_write & ~r_fp[r_head] & (r_waddr[r_head] != 5'd0);
        // A retiring head frees a slot in the same cycle, so a full
        // buffer can still accept.
        w_ready     = (r_count < C_DEPTH_CNT) | w_retire;
        w_enq       = wb.en_wb_i & w_ready;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [31:0] w_pend_int;
    logic [31:0] w_pend_fp;
    logic        w_out_load;
    logic        w_out_store;

    always_comb begin
        w_pend_int  = '0;
        w_pend_fp   = '0;
        w_out_load  = 1'b0;
        w_out_store = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (r_valid[i]) begin
                if (r_we[i]) begin
                    if (r_fp[i]) begin
                        w_pend_fp[r_waddr[i]] = 1'b1;
                    end else begin
                        w_pend_int[r_waddr[i]] = 1'b1;
                    end
                end
                if (r_type[i] == C_TYPE_LOAD) begin
                    w_out_load = 1'b1;
                end
                if (r_type[i] == C_TYPE_STORE) begin
                    w_out_store = 1'b1;
                end
            end
        end
        w_pend_int[0] = 1'b0;
    end

    assign wb.ready_wb_o             = w_ready;
    assign wb.rf_we_int_wb_o         = w_we_int;
    assign wb.rf_we_fp_wb_o          = w_we_fp;
    assign wb.rf_waddr_wb_o          = (w_we_int | w_we_fp) ? r_waddr[r_head] : 5'd0;
    assign wb.rf_wdata_wb_o          = ~(w_we_int | w_we_fp) ? '0 :
                                       w_head_load ? wb.rf_wdata_lsu_i : r_wdata[r_head];
    assign wb.pending_int_o          = w_pend_int;
    assign wb.pending_fp_o           = w_pend_fp;
    assign wb.outstanding_load_wb_o  = w_out_load;
    assign wb.outstanding_store_wb_o = w_out_store;
    assign wb.pc_wb_o                = w_nonempty ? r_pc[r_head] : 32'd0;
    assign wb.instr_done_wb_o        = w_retire;
    assign wb.perf_instr_ret_wb_o    = w_retire & r_cnt[r_head] & ~w_lsu_err;
    assign wb.perf_instr_ret_compressed_wb_o =
                                       w_retire & r_cnt[r_head] & ~w_lsu_err & r_cmp[r_head];

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_type[i]  <= '0;
                r_waddr[i] <= '0;
                r_wdata[i] <= '0;
                r_we[i]    <= 1'b0;
                r_fp[i]    <= 1'b0;
                r_pc[i]    <= '0;
                r_cmp[i]   <= 1'b0;
                r_cnt[i]   <= 1'b0;
            end
        end else begin
            // Retire clears first so that a simultaneous enqueue into the
            // same slot (full buffer, head == tail) wins.
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= f_next_ptr(r_head);
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_type[r_tail]  <= wb.instr_type_wb_i;
                r_waddr[r_tail] <= wb.rf_waddr_id_i;
                r_wdata[r_tail] <= wb.rf_wdata_id_i;
                r_we[r_tail]    <= wb.rf_we_id_i;
                r_fp[r_tail]    <= wb.rf_dst_fp_id_i;
                r_pc[r_tail]    <= wb.pc_id_i;
                r_cmp[r_tail]   <= wb.instr_is_compressed_id_i;
                r_cnt[r_tail]   <= wb.instr_perf_count_id_i;
                r_tail          <= f_next_ptr(r_tail);
            end
            case ({w_enq, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibex_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibex_wb_buffer
//  Description : Self-checking bench for ibex_wb_buffer (Depth = 2). A queue
//                of instructions models the buffer; every cycle the expected
//                outputs are derived from the queue head and the LSU inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_wb_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam logic [1:0] T_LOAD  = 2'b00;
    localparam logic [1:0] T_STORE = 2'b01;
    localparam logic [1:0] T_OTHER = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ibex_wb_buffer_if #(.DataWidth(DW)) bus ();

    ibex_wb_buffer #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus)
    );

    typedef struct {
        logic [1:0]  t;
        logic [4:0]  a;
        logic [31:0] d;
        logic        we;
        logic        fp;
        logic [31:0] pc;
        logic        c;
        logic        n;
    } ent_t;

    ent_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [1:0] t, input logic [4:0] a, input logic [31:0] d,
                         input logic we, input logic fp);
        bus.en_wb_i                  = 1'b1;
        bus.instr_type_wb_i          = t;
        bus.rf_waddr_id_i            = a;
        bus.rf_wdata_id_i            = d;
        bus.rf_we_id_i               = we;
        bus.rf_dst_fp_id_i           = fp;
        bus.pc_id_i                  = pc_ctr;
        bus.instr_is_compressed_id_i = pc_ctr[2];
        bus.instr_perf_count_id_i    = 1'b1;
        pc_ctr                       = pc_ctr + 32'd4;
    endtask

    task automatic lsu(input logic v, input logic e, input logic [31:0] d);
        bus.lsu_resp_valid_i = v;
        bus.lsu_resp_err_i   = e;
        bus.rf_wdata_lsu_i   = d;
    endtask

    // Called at a negedge with inputs already applied: checks the outputs
    // against the model, then advances one clock and updates the model.
    task automatic cycle();
        ent_t        h;
        bit          has, lsu_head, ret, err, wr, e_fp, e_int, rdy, perf;
        logic [31:0] m_int, m_fp, e_d;
        logic [4:0]  e_a;
        bit          ld, st;
        #1;
        has = (q.size() > 0);
        h   = has ? q[0] : '{default: '0};
        lsu_head = has && (h.t == T_LOAD || h.t == T_STORE);
        ret  = has && (!lsu_head || bus.lsu_resp_valid_i);
        err  = lsu_head && bus.lsu_resp_valid_i && bus.lsu_resp_err_i;
        wr   = ret && h.we && (h.t != T_STORE) && !err;
        e_fp = wr && h.fp;
        e_int = wr && !h.fp && (h.a != 5'd0);
        e_a  = (e_fp || e_int) ? h.a : 5'd0;
        e_d  = (e_fp || e_int) ? ((h.t == T_LOAD) ? bus.rf_wdata_lsu_i : h.d) : 32'd0;
        rdy  = (q.size() < DEPTH) || ret;
        perf = ret && h.n && !err;
        m_int = '0; m_fp = '0; ld = 0; st = 0;
        foreach (q[i]) begin
            if (q[i].we && q[i].fp)  m_fp[q[i].a]  = 1'b1;
            if (q[i].we && !q[i].fp) m_int[q[i].a] = 1'b1;
            if (q[i].t == T_LOAD)  ld = 1;
            if (q[i].t == T_STORE) st = 1;
        end
        m_int[0] = 1'b0;

        chk("ready",      64'(bus.ready_wb_o),      64'(rdy));
        chk("we_int",     64'(bus.rf_we_int_wb_o),  64'(e_int));
        chk("we_fp",      64'(bus.rf_we_fp_wb_o),   64'(e_fp));
        chk("waddr",      64'(bus.rf_waddr_wb_o),   64'(e_a));
        chk("wdata",      64'(bus.rf_wdata_wb_o),   64'(e_d));
        chk("pend_int",   64'(bus.pending_int_o),   64'(m_int));
        chk("pend_fp",    64'(bus.pending_fp_o),    64'(m_fp));
        chk("out_load",   64'(bus.outstanding_load_wb_o),  64'(ld));
        chk("out_store",  64'(bus.outstanding_store_wb_o), 64'(st));
        chk("pc",         64'(bus.pc_wb_o),         64'(has ? h.pc : 32'd0));
        chk("done",       64'(bus.instr_done_wb_o), 64'(ret));
        chk("perf",       64'(bus.perf_instr_ret_wb_o), 64'(perf));
        chk("perf_c",     64'(bus.perf_instr_ret_compressed_wb_o), 64'(perf && h.c));

        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (bus.en_wb_i && rdy) begin
                q.push_back('{t: bus.instr_type_wb_i, a: bus.rf_waddr_id_i,
                              d: bus.rf_wdata_id_i, we: bus.rf_we_id_i,
                              fp: bus.rf_dst_fp_id_i, pc: bus.pc_id_i,
                              c: bus.instr_is_compressed_id_i,
                              n: bus.instr_perf_count_id_i});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.en_wb_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.instr_type_wb_i = T_OTHER; bus.rf_waddr_id_i = '0; bus.rf_wdata_id_i = '0;
        bus.rf_we_id_i = 0; bus.rf_dst_fp_id_i = 0; bus.pc_id_i = '0;
        bus.instr_is_compressed_id_i = 0; bus.instr_perf_count_id_i = 0;
        lsu(0, 0, 32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);

        // reset state, with an offer that must not enqueue during reset
        offer(T_OTHER, 5'd9, 32'h1111_1111, 1, 0);
        cycle();
        rst = 1'b0; idle();
        cycle();
        chk("reset_empty", 64'(q.size()), 64'd0);

        // OTHER, int x5, data 0xA5A5A5A5
        offer(T_OTHER, 5'd5, 32'hA5A5_A5A5, 1, 0); cycle();
        idle(); cycle(); cycle();

        // LOAD to f3, response three cycles later
        offer(T_LOAD, 5'd3, 32'hDEAD_0000, 1, 1); cycle();
        idle(); cycle(); cycle(); cycle();
        lsu(1, 0, 32'h1234_5678); cycle();
        lsu(0, 0, 32'd0); cycle();

        // LOAD followed by OTHER x7; stalls while full without response
        offer(T_LOAD, 5'd12, 32'd0, 1, 0); cycle();
        offer(T_OTHER, 5'd7, 32'h0000_0777, 1, 0); cycle();
        offer(T_OTHER, 5'd8, 32'h0000_0888, 1, 0); cycle(); cycle();
        idle(); lsu(1, 0, 32'hCAFE_F00D); cycle();
        lsu(0, 0, 32'd0); cycle(); cycle();

        // LOAD with error response, then STORE
        offer(T_LOAD, 5'd14, 32'd0, 1, 0); cycle();
        idle(); lsu(1, 1, 32'hBAD0_BAD0); cycle();
        offer(T_STORE, 5'd15, 32'h5555_5555, 0, 0); lsu(0, 0, 32'd0); cycle();
        idle(); lsu(1, 0, 32'd0); cycle();
        lsu(0, 0, 32'd0);

        // stray LSU response while empty is ignored
        lsu(1, 1, 32'hFFFF_FFFF); cycle();
        lsu(0, 0, 32'd0);

        // full buffer with loads retiring and enqueuing back-to-back
        offer(T_LOAD, 5'd1, 32'd0, 1, 0); cycle();
        offer(T_LOAD, 5'd2, 32'd0, 1, 1); cycle();
        for (int k = 0; k < 10; k++) begin
            offer(T_LOAD, 5'(k + 16), 32'd0, 1, k[0]);
            lsu(1, 0, 32'h100 + 32'(k));
            cycle();
            chk("full_occ", 64'(q.size()), 64'(DEPTH));
        end
        idle(); lsu(0, 0, 32'd0);

        // reset with two entries pending, then OTHER to x0
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        offer(T_OTHER, 5'd0, 32'h0BAD_0BAD, 1, 0); cycle();
        idle(); cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0) begin
                offer(2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                bus.instr_perf_count_id_i = ($urandom_range(0, 3) != 0);
            end else begin
                idle();
            end
            lsu(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
